// File: rtl/uart_rx_seg_display.sv
// uart_rx_seg_display: captures received UART bytes into a 4-digit hex history buffer
// (digit 0 = newest) and scans it onto a common-anode 4-digit 7-segment display.
// Errored bytes are dropped and raise an error indicator shown on digit 0's decimal point.
// Optional feature macro: RXDISP_ASCII_EN (decode ASCII hex characters instead of the raw
// low nibble; non-hex characters are ignored).
module uart_rx_seg_display #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  Rx_DATA,
  input  logic        Rx_VALID,
  input  logic        Rx_FERROR,
  input  logic        Rx_PERROR,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] digits,
  output logic        new_byte
);

  localparam int unsigned NIB_W = 4;
  localparam int unsigned BUF_W = 16;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 2;

  logic               rx_valid_q, rx_valid_d;
  logic [BUF_W-1:0]   digits_q, digits_d;
  logic               err_q, err_d;
  logic               new_byte_q, new_byte_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic               accept;
  logic               nib_ok;
  logic [NIB_W-1:0]   nib;
  logic [NIB_W-1:0]   cur_nib;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a hex digit
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Byte-to-nibble mapping; returns {valid, nibble}
  function automatic logic [4:0] byte_to_nib(input logic [7:0] b);
`ifdef RXDISP_ASCII_EN
    if (b >= 8'h30 && b <= 8'h39)
      byte_to_nib = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      byte_to_nib = {1'b1, 4'(b[3:0] + 4'd9)};
    else
      byte_to_nib = 5'b0_0000;
`else
    byte_to_nib = {1'b1, b[3:0]};
`endif
  endfunction

  // Capture, scan sequencing and registered display outputs
  always_comb begin
    rx_valid_d = Rx_VALID;
    digits_d   = digits_q;
    err_d      = err_q;
    new_byte_d = 1'b0;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    accept     = Rx_VALID & ~rx_valid_q;
    {nib_ok, nib} = byte_to_nib(Rx_DATA);
    cur_nib    = digits_q[3:0];

    // Error flags win over the data; unrecognised bytes leave everything untouched
    if (accept) begin
      if (Rx_FERROR | Rx_PERROR) begin
        err_d = 1'b1;
      end else if (nib_ok) begin
        digits_d   = {digits_q[11:0], nib};
        err_d      = 1'b0;
        new_byte_d = 1'b1;
      end
    end

    if (cnt_q == SCAN_DIV - 16'd1) begin
      cnt_d = '0;
      idx_d = IDX_W'(idx_q + 2'd1);
    end else begin
      cnt_d = CNT_W'(cnt_q + 16'd1);
    end

    case (idx_q)
      2'd0:    cur_nib = digits_q[3:0];
      2'd1:    cur_nib = digits_q[7:4];
      2'd2:    cur_nib = digits_q[11:8];
      default: cur_nib = digits_q[15:12];
    endcase

    an_d  = ~(4'b0001 << idx_q);
    seg_d = hex_to_seg(cur_nib);
    dp_d  = ~((idx_q == 2'd0) & err_q);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_valid_q <= 1'b0;
      digits_q   <= '0;
      err_q      <= 1'b0;
      new_byte_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1111;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
    end else begin
      rx_valid_q <= rx_valid_d;
      digits_q   <= digits_d;
      err_q      <= err_d;
      new_byte_q <= new_byte_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign digits   = digits_q;
  assign new_byte = new_byte_q;

endmodule

// File: tb/tb_uart_rx_seg_display.sv
// Directed testbench for uart_rx_seg_display with a short scan period (SCAN_DIV=4).
module tb_uart_rx_seg_display;

  logic        clk;
  logic        reset;
  logic [7:0]  Rx_DATA;
  logic        Rx_VALID;
  logic        Rx_FERROR;
  logic        Rx_PERROR;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] digits;
  logic        new_byte;

  int checks;
  int errors;

  uart_rx_seg_display #(.SCAN_DIV(16'd4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Rx_DATA   (Rx_DATA),
    .Rx_VALID  (Rx_VALID),
    .Rx_FERROR (Rx_FERROR),
    .Rx_PERROR (Rx_PERROR),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .digits    (digits),
    .new_byte  (new_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle Rx_VALID pulse; returns new_byte as seen the cycle after acceptance
  task automatic send_byte(input logic [7:0] b, input logic fe, input logic pe, output logic nb);
    @(negedge clk);
    Rx_DATA = b; Rx_VALID = 1'b1; Rx_FERROR = fe; Rx_PERROR = pe;
    @(negedge clk);
    nb = new_byte;
    Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", an); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b exp 1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h exp 0000", digits); end
    checks++; if (new_byte !== 1'b0) begin errors++; $display("FAIL reset_new_byte got %b exp 0", new_byte); end
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_an = 4'b0001 << (k / 4);
      exp_an = ~exp_an;
      checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an cyc %0d got %b exp %b", k, an, exp_an); end
      checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL scan_seg cyc %0d got %b exp 1000000", k, seg); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp cyc %0d got %b exp 1", k, dp); end
    end
  endtask

  task automatic test_raw_bytes();
    logic [7:0] bytes [4];
    logic nb;
    int pulses;
    bit found;
    bytes[0] = 8'h31; bytes[1] = 8'h32; bytes[2] = 8'h33; bytes[3] = 8'h34;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], 1'b0, 1'b0, nb);
      if (nb === 1'b1) pulses++;
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL bytes_pulses got %0d exp 4", pulses); end
    checks++; if (digits !== 16'h1234) begin errors++; $display("FAIL bytes_digits got %h exp 1234", digits); end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (an === 4'b1110) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL bytes_wait_an got %b exp 1110", an); end
    checks++; if (seg !== 7'b0011001) begin errors++; $display("FAIL bytes_seg_d0 got %b exp 0011001", seg); end
  endtask

  task automatic test_held_valid();
    int pulses;
    pulses = 0;
    @(negedge clk);
    Rx_DATA = 8'h35; Rx_VALID = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (new_byte === 1'b1) pulses++;
    end
    Rx_VALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (new_byte === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL held_pulses got %0d exp 1", pulses); end
    checks++; if (digits !== 16'h2345) begin errors++; $display("FAIL held_digits got %h exp 2345", digits); end
  endtask

  task automatic test_error();
    logic nb;
    logic exp_dp;
    logic [15:0] exp_digits;
    bit saw_low;
    exp_digits = 16'h2345;
    for (int r = 0; r < 2; r++) begin
      send_byte(8'h37, 1'(r == 1), 1'(r == 0), nb);
      checks++; if (nb !== 1'b0) begin errors++; $display("FAIL err%0d_new_byte got %b exp 0", r, nb); end
      checks++; if (digits !== exp_digits) begin errors++; $display("FAIL err%0d_digits got %h exp %h", r, digits, exp_digits); end
      @(negedge clk);
      saw_low = 1'b0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        exp_dp = (an === 4'b1110) ? 1'b0 : 1'b1;
        if (dp === 1'b0) saw_low = 1'b1;
        checks++; if (dp !== exp_dp) begin errors++; $display("FAIL err%0d_dp an %b got %b exp %b", r, an, dp, exp_dp); end
      end
      checks++; if (!saw_low) begin errors++; $display("FAIL err%0d_dp_seen got 0 exp 1", r); end
      send_byte(8'h32, 1'b0, 1'b0, nb);
      exp_digits = {exp_digits[11:0], 4'h2};
      checks++; if (nb !== 1'b1) begin errors++; $display("FAIL err%0d_recover_new_byte got %b exp 1", r, nb); end
      checks++; if (digits !== exp_digits) begin errors++; $display("FAIL err%0d_recover_digits got %h exp %h", r, digits, exp_digits); end
      @(negedge clk);
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL err%0d_dp_clear got %b exp 1", r, dp); end
      end
    end
  endtask

  task automatic test_ascii();
    logic [7:0] bytes [4];
    logic nb;
    logic [15:0] exp_digits;
    int exp_pulses;
    int pulses;
`ifdef RXDISP_ASCII_EN
    exp_digits = 16'h0AF9; exp_pulses = 3;
`else
    exp_digits = 16'h169A; exp_pulses = 4;
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bytes[0] = 8'h61; bytes[1] = 8'h46; bytes[2] = 8'h39; bytes[3] = 8'h7A;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], 1'b0, 1'b0, nb);
      if (nb === 1'b1) pulses++;
    end
    checks++; if (pulses != exp_pulses) begin errors++; $display("FAIL ascii_pulses got %0d exp %0d", pulses, exp_pulses); end
    checks++; if (digits !== exp_digits) begin errors++; $display("FAIL ascii_digits got %h exp %h", digits, exp_digits); end
  endtask

  task automatic test_reset_mid_scan();
    logic [7:0] bytes [4];
    logic nb;
    bit found;
`ifdef RXDISP_ASCII_EN
    bytes[0] = 8'h42; bytes[1] = 8'h45; bytes[2] = 8'h65; bytes[3] = 8'h46;
`else
    bytes[0] = 8'h0B; bytes[1] = 8'h0E; bytes[2] = 8'h0E; bytes[3] = 8'h0F;
`endif
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b0, 1'b0, nb);
    checks++; if (digits !== 16'hBEEF) begin errors++; $display("FAIL mid_digits got %h exp beef", digits); end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (an === 4'b1011) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_wait_an got %b exp 1011", an); end
    reset = 1'b0; Rx_DATA = 8'h37; Rx_VALID = 1'b1;
    @(negedge clk);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL mid_an got %b exp 1111", an); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL mid_seg got %b exp 1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL mid_dp got %b exp 1", dp); end
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL mid_digits_clr got %h exp 0000", digits); end
    checks++; if (new_byte !== 1'b0) begin errors++; $display("FAIL mid_new_byte got %b exp 0", new_byte); end
    reset = 1'b1;
    @(negedge clk);
    Rx_VALID = 1'b0;
    checks++; if (new_byte !== 1'b1) begin errors++; $display("FAIL post_rst_edge got %b exp 1", new_byte); end
    checks++; if (digits !== 16'h0007) begin errors++; $display("FAIL post_rst_digits got %h exp 0007", digits); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL post_rst_an0 got %b exp 1110", an); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (an !== 4'b1110) begin errors++; $display("FAIL post_rst_an cyc %0d got %b exp 1110", c, an); end
    end
    @(negedge clk);
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL post_rst_an_adv got %b exp 1101", an); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; Rx_DATA = 8'h00; Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
    test_reset();
    test_raw_bytes();
    test_held_valid();
    test_error();
    test_ascii();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
